// File: rtl/riscv_alu.sv
// riscv_alu: 32-bit RV32 integer ALU with sticky signed-overflow flag.
// Ports: clk/rst (async active-high) clock the ovf flag and optional output
//   register; ALUctl selects the operation; A/B are operands; ALUout is the
//   result; zero is 1 when ALUout == 0; ovf is sticky ADD/SUB signed overflow.
// Option: define RISCVALU_OUTREG_EN to register ALUout/zero (1-cycle latency).
module riscv_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUout,
    output logic             zero,
    output logic             ovf
);
    localparam int SW = $clog2(WIDTH);
    logic [WIDTH-1:0] sum, diff, res;
    logic [SW-1:0]    sh;
    logic             ovf_d, ovf_q;
    assign sum  = A + B;
    assign diff = A - B;
    assign sh   = B[SW-1:0];
    always_comb begin
        res = '0;
        case (ALUctl)
            4'b0000: res = A & B;
            4'b0001: res = A | B;
            4'b0010: res = sum;
            4'b0011: res = A ^ B;
            4'b0100: res = A << sh;
            4'b0101: res = A >> sh;
            4'b0110: res = diff;
            4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'b1000: res = {{(WIDTH-1){1'b0}}, A < B};
            4'b1001: res = $signed(A) >>> sh;
            4'b1100: res = ~(A | B);
            default: res = '0;
        endcase
    end
    // Signed overflow: operands agree (ADD) or differ (SUB) in sign and the
    // result's sign departs from A.
    always_comb begin
        ovf_d = ovf_q
              | (ALUctl == 4'b0010 && A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1])
              | (ALUctl == 4'b0110 && A[WIDTH-1] != B[WIDTH-1] && diff[WIDTH-1] != A[WIDTH-1]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`ifdef RISCVALU_OUTREG_EN
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            out_q  <= res;
            zero_q <= (res == '0);
        end
    end
    assign ALUout = out_q;
    assign zero   = zero_q;
`else
    assign ALUout = res;
    assign zero   = (res == '0);
`endif
endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: directed-vector self-checking bench for riscv_alu.
module tb_riscv_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ALUctl = 4'b0000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] ALUout;
    logic        zero;
    logic        ovf;
    int total = 0;
    int bad = 0;

    riscv_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ALUctl(ALUctl), .A(A), .B(B),
        .ALUout(ALUout), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALUctl = c;
        A = a;
        B = b;
`ifdef RISCVALU_OUTREG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic vec(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r);
        apply(c, a, b);
        chk({tag, ".out"}, ALUout, r);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, r == 32'h0});
    endtask

    initial begin
        #2;
        chk("rst.out", ALUout, 32'h0);
        chk("rst.zero", {31'b0, zero}, 32'h1);
        chk("rst.ovf", {31'b0, ovf}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        vec("and",   4'b0000, 32'h0000000F, 32'h0000000A, 32'h0000000A);
        vec("or",    4'b0001, 32'h00000000, 32'h0000000A, 32'h0000000A);
        vec("add",   4'b0010, 32'd9, 32'd1, 32'd10);
        vec("sub",   4'b0110, 32'd8, 32'd2, 32'd6);
        vec("sub0",  4'b0110, 32'd5, 32'd5, 32'd0);
        vec("xor",   4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
        vec("slt1",  4'b0111, 32'd8, 32'd9, 32'd1);
        vec("slt0",  4'b0111, 32'd10, 32'd9, 32'd0);
        vec("sltn",  4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1);
        vec("sltun", 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0);
        vec("sltm",  4'b0111, 32'h80000000, 32'd0, 32'd1);
        vec("sltum", 4'b1000, 32'h80000000, 32'd0, 32'd0);
        vec("nor",   4'b1100, 32'h00000000, 32'h0000000A, 32'hFFFFFFF5);
        vec("sra",   4'b1001, 32'h80000000, 32'd4, 32'hF8000000);
        vec("srl",   4'b0101, 32'h80000000, 32'd4, 32'h08000000);
        vec("sllhi", 4'b0100, 32'h00000001, 32'h00000024, 32'h00000010);
        vec("sll0",  4'b0100, 32'h12345678, 32'h00000020, 32'h12345678);
        vec("sra0",  4'b1001, 32'h87654321, 32'hFFFFFFE0, 32'h87654321);
        vec("udef",  4'b1111, 32'd5, 32'd3, 32'd0);
        vec("udefa", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
        @(posedge clk);
        #1;
        chk("ovf.clean", {31'b0, ovf}, 32'h0);
`ifdef RISCVALU_OUTREG_EN
        @(negedge clk);
        ALUctl = 4'b0010;
        A = 32'd3;
        B = 32'd4;
        #1;
        chk("lat.hold", ALUout, 32'd0);
        @(posedge clk);
        #1;
        chk("lat.upd", ALUout, 32'd7);
`endif
        vec("addovf", 4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000);
        @(posedge clk);
        #1;
        chk("ovf.set", {31'b0, ovf}, 32'h1);
        vec("andkeep", 4'b0000, 32'h0000000F, 32'h0000000A, 32'h0000000A);
        @(posedge clk);
        #1;
        chk("ovf.keep", {31'b0, ovf}, 32'h1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("ovf.arst", {31'b0, ovf}, 32'h0);
        rst = 1'b0;
        vec("subovf", 4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF);
        @(posedge clk);
        #1;
        chk("ovf.sub", {31'b0, ovf}, 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
